// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential MSD-first multi-digit BCD to binary decoder with start/ready/done handshake
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);
    localparam int CW = $clog2(DIGITS + 1);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t state, state_nxt;
    logic [4*DIGITS-1:0] sr;
    logic [BIN_W-1:0] acc, acc_nxt;
    logic [CW-1:0] cnt;
    logic err_c, err_r, last;
    assign ready   = state == IDLE;
    assign done    = state == DONE;
    assign last    = cnt == CW'(DIGITS - 1);
    assign acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(sr[4*DIGITS-1 -: 4]);
    // flag any non-decimal nibble in the incoming word
    always_comb begin
        err_c = 1'b0;
        for (int i = 0; i < DIGITS; i++) err_c = err_c | (bcd_in[4*i +: 4] > 4'd9);
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // next state: accept in IDLE, run DIGITS steps, one DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? CONV : IDLE;
            CONV:    state_nxt = last ? DONE : CONV;
            default: state_nxt = IDLE;
        endcase
    end
    // datapath: capture, accumulate acc*10+digit, publish result on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_r   <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
        end else if (state == IDLE && start) begin
            sr    <= bcd_in;
            err_r <= err_c;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == CONV) begin
            acc <= acc_nxt;
            sr  <= sr << 4;
            cnt <= cnt + CW'(1);
            if (last) begin
                bin_out <= err_r ? '0 : acc_nxt;
                err     <= err_r;
            end
        end
    end
endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential multi-digit BCD-to-binary decoder; the inverse direction of the team's decimal-to-BCD encoding path.
- Accepts a packed DIGITS-digit BCD word on a start/ready handshake.
- Converts MSD-first, one digit per clock, using acc = acc*10 + digit.
- Presents the binary result with a one-cycle done pulse.
- Used wherever keypad/display BCD values must feed binary arithmetic.

Parameters:
- DIGITS, 4, number of BCD digits in bcd_in (≥1).
- BIN_W, 14, result width; must be ≥ ceil(log2(10^DIGITS)); 14 covers 9999.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; accepted only when ready=1.
- bcd_in  input  4*DIGITS  packed BCD; digit i at bits [4i+3:4i], digit DIGITS-1 is MSD.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse; bin_out/err valid.
- bin_out  output  BIN_W  binary result; held until the next accepted start.
- err  output  1  set if any captured digit > 9; held with bin_out.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n); all flops clear immediately on rst_n=0.
- Reset values: state=IDLE, ready=1, done=0, bin_out=0, err=0, internal accumulator/shift register/digit counter = 0.
- States: IDLE, CONV, DONE. ready = (state==IDLE).
- IDLE:
  - On a rising edge with start=1, capture bcd_in into a shift register.
  - Compute err_c = OR over all digits of (digit > 9); register it.
  - Clear acc and the counter; go to CONV.
  - start=0 → stay in IDLE; bin_out/err hold.
- CONV:
  - Each edge: acc ← (acc<<3) + (acc<<1) + MSD of the shift register, truncated to BIN_W.
  - Shift the register left by 4; counter++.
  - After the DIGITS-th update, go to DONE.
  - start is ignored (ready=0); bcd_in changes are ignored.
- DONE (exactly one cycle):
  - done=1; bin_out = err ? 0 : acc; err = registered err_c.
  - Next edge → IDLE unconditionally. start during DONE is ignored.
- Latency: start high in cycle 0 → done high in cycle DIGITS+1 → ready high again in cycle DIGITS+2. Throughput: one conversion per DIGITS+2 cycles.
- bin_out and err update only on entry to DONE; they are stable at all other times.
- Invalid digits (A–F) are still processed through the full latency. The result is forced to 0 with err=1; no early abort.
- Arithmetic is unsigned. Overflow cannot occur when BIN_W meets the constraint; any excess is truncated silently.
- Reset asserted mid-CONV or in DONE aborts immediately to reset values. No done pulse is produced for the aborted request.
- done is never high while ready is high.

Test Plan:
- Reset, then start with bcd_in=16'h0000 → done in cycle 5, bin_out=0, err=0; ready returns in cycle 6.
- bcd_in=16'h1234 → bin_out=14'd1234 (0x04D2), err=0; done asserted exactly 5 cycles after the start cycle, width 1 cycle.
- bcd_in=16'h9999 → bin_out=14'd9999 (0x270F), err=0. Then bcd_in=16'h0001 back-to-back at the first ready cycle → bin_out=1.
- bcd_in=16'h12A4 → err=1, bin_out=0 at done; next conversion of 16'h0042 → err=0, bin_out=42.
- Start at 16'h0500, then hold start=1 and change bcd_in to 16'h0777 during CONV → only one done, bin_out=500; second conversion (777) starts only after ready=1.
- Start at 16'h4321, drive rst_n=0 in cycle 2 for 1 cycle → outputs zero asynchronously, no done pulse. A new start at 16'h0008 → bin_out=8.
